// File: rtl/pipe_pkg.sv
// Shared definitions for the handshaked pipeline-stage registers.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } pipe_state_e;

    // RISC-V "addi x0, x0, 0", used to build the IF/ID bubble payload
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline-stage register: optional 2-entry skid buffer with a
// registered upstream ready, synchronous flush to a bubble payload.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                WIDTH  = 64,
    parameter bit                SKID   = 1'b1,
    parameter logic [WIDTH-1:0]  BUBBLE = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic [1:0]       count_o
);

    if (SKID) begin : g_skid
        pipe_state_e      st_q, st_d;
        logic [WIDTH-1:0] head_q, head_d;
        logic [WIDTH-1:0] skid_q, skid_d;
        logic             rdy_q;
        logic             in_hs, out_hs;

        assign in_hs  = in_valid_i & rdy_q;
        assign out_hs = (st_q != ST_EMPTY) & out_ready_i;

        always_comb begin
            st_d   = st_q;
            head_d = head_q;
            skid_d = skid_q;
            unique case (st_q)
                ST_EMPTY: begin
                    if (in_hs) begin
                        st_d   = ST_ONE;
                        head_d = in_data_i;
                    end
                end
                ST_ONE: begin
                    if (in_hs && out_hs) begin
                        head_d = in_data_i;
                    end else if (in_hs) begin
                        st_d   = ST_FULL;
                        skid_d = in_data_i;
                    end else if (out_hs) begin
                        st_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_hs) begin
                        st_d   = ST_ONE;
                        head_d = skid_q;
                    end
                end
                default: st_d = ST_EMPTY;
            endcase
            // Flush wins: a delivery this cycle still counts, inputs are dropped
            if (flush_i) begin
                st_d   = ST_EMPTY;
                head_d = BUBBLE;
            end
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                st_q   <= ST_EMPTY;
                head_q <= BUBBLE;
                skid_q <= BUBBLE;
                rdy_q  <= 1'b1;
            end else begin
                st_q   <= st_d;
                head_q <= head_d;
                skid_q <= skid_d;
                rdy_q  <= (st_d != ST_FULL);
            end
        end

        assign in_ready_o  = rdy_q;
        assign out_valid_o = (st_q != ST_EMPTY);
        assign out_data_o  = head_q;
        assign count_o     = st_q;
    end else begin : g_noskid
        logic             vld_q;
        logic [WIDTH-1:0] head_q;
        logic             rdy;

        // Ready looks through to downstream so a full head can be replaced
        assign rdy = ~vld_q | out_ready_i;

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                vld_q  <= 1'b0;
                head_q <= BUBBLE;
            end else if (flush_i) begin
                vld_q  <= 1'b0;
                head_q <= BUBBLE;
            end else if (in_valid_i && rdy) begin
                vld_q  <= 1'b1;
                head_q <= in_data_i;
            end else if (vld_q && out_ready_i) begin
                vld_q <= 1'b0;
            end
        end

        assign in_ready_o  = rdy;
        assign out_valid_o = vld_q;
        assign out_data_o  = head_q;
        assign count_o     = {1'b0, vld_q};
    end

endmodule
